// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Brief    : MEM-stage load/store control: alignment check, lane mask/data
//            build, single-shot cache request, load extension, watchdog abort.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_unsigned_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              cpu_rd_req_o,
    output logic              cpu_wr_req_o,
    output logic [ADDR_W-1:0] cpu_addr_o,
    output logic [DATA_W-1:0] cpu_wr_data_o,
    output logic [3:0]        cpu_wr_en_o,
    input  logic [DATA_W-1:0] cpu_rd_data_i,
    input  logic              cache_stall_i,
    output logic              lsu_stall_o,
    output logic              lsu_done_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              misalign_o,
    output logic              bus_err_o
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [1:0]       r_size;
    logic             r_unsigned;
    logic [1:0]       r_off;

    logic              w_illegal;
    logic              w_accept;
    logic [3:0]        w_mask;
    logic [DATA_W-1:0] w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;

    always_comb begin
        w_illegal = 1'b0;
        w_mask    = 4'b0000;
        w_wdata   = '0;
        case (mem_size_i)
            2'b00: begin
                w_mask  = 4'b0001 << mem_addr_i[1:0];
                w_wdata = {4{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                w_illegal = mem_addr_i[0];
                w_mask    = 4'b0011 << {mem_addr_i[1], 1'b0};
                w_wdata   = {2{mem_wdata_i[15:0]}};
            end
            2'b10: begin
                w_illegal = (mem_addr_i[1:0] != 2'b00);
                w_mask    = 4'b1111;
                w_wdata   = mem_wdata_i;
            end
            default: w_illegal = 1'b1;
        endcase
        // Loads never touch the write lanes.
        if (!mem_we_i) begin
            w_mask  = 4'b0000;
            w_wdata = '0;
        end
    end

    assign w_accept    = (r_state == S_IDLE) && mem_req_i && !w_illegal;
    assign lsu_stall_o = (r_state == S_REQ) || (r_state == S_WAIT) || w_accept;

    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0:    w_byte = cpu_rd_data_i[7:0];
            2'd1:    w_byte = cpu_rd_data_i[15:8];
            2'd2:    w_byte = cpu_rd_data_i[23:16];
            default: w_byte = cpu_rd_data_i[31:24];
        endcase
        w_half = r_off[1] ? cpu_rd_data_i[31:16] : cpu_rd_data_i[15:0];
        case (r_size)
            2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load = cpu_rd_data_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_size        <= 2'b00;
            r_unsigned    <= 1'b0;
            r_off         <= 2'b00;
            cpu_rd_req_o  <= 1'b0;
            cpu_wr_req_o  <= 1'b0;
            cpu_addr_o    <= '0;
            cpu_wr_data_o <= '0;
            cpu_wr_en_o   <= 4'b0000;
            lsu_done_o    <= 1'b0;
            lsu_rdata_o   <= '0;
            misalign_o    <= 1'b0;
            bus_err_o     <= 1'b0;
        end else begin
            cpu_rd_req_o <= 1'b0;
            cpu_wr_req_o <= 1'b0;
            lsu_done_o   <= 1'b0;
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_req_i) begin
                        if (w_illegal) begin
                            misalign_o <= 1'b1;
                        end else begin
                            r_we          <= mem_we_i;
                            r_size        <= mem_size_i;
                            r_unsigned    <= mem_unsigned_i;
                            r_off         <= mem_addr_i[1:0];
                            cpu_addr_o    <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                            cpu_wr_en_o   <= w_mask;
                            cpu_wr_data_o <= w_wdata;
                            cpu_rd_req_o  <= !mem_we_i;
                            cpu_wr_req_o  <= mem_we_i;
                            r_state       <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cache_stall_i) begin
                        if (r_cnt == c_cnt_last) begin
                            bus_err_o     <= 1'b1;
                            cpu_addr_o    <= '0;
                            cpu_wr_en_o   <= 4'b0000;
                            cpu_wr_data_o <= '0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        lsu_rdata_o <= r_we ? '0 : w_load;
                        lsu_done_o  <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    cpu_addr_o    <= '0;
                    cpu_wr_en_o   <= 4'b0000;
                    cpu_wr_data_o <= '0;
                    lsu_rdata_o   <= '0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Brief    : Directed vector bench for lsu_mem_ctrl with timeout/reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_size_i;
    logic        mem_unsigned_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        cpu_rd_req_o;
    logic        cpu_wr_req_o;
    logic [31:0] cpu_addr_o;
    logic [31:0] cpu_wr_data_o;
    logic [3:0]  cpu_wr_en_o;
    logic [31:0] cpu_rd_data_i;
    logic        cache_stall_i;
    logic        lsu_stall_o;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        misalign_o;
    logic        bus_err_o;

    lsu_mem_ctrl #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16), .CNT_W(5)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
        .mem_unsigned_i(mem_unsigned_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .cpu_rd_req_o(cpu_rd_req_o), .cpu_wr_req_o(cpu_wr_req_o),
        .cpu_addr_o(cpu_addr_o), .cpu_wr_data_o(cpu_wr_data_o),
        .cpu_wr_en_o(cpu_wr_en_o), .cpu_rd_data_i(cpu_rd_data_i),
        .cache_stall_i(cache_stall_i), .lsu_stall_o(lsu_stall_o),
        .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          stalls;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
    } bad_t;

    vec_t vecs[12];
    bad_t bads[4];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_op(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
        mem_req_i      = 1'b1;
        mem_we_i       = we;
        mem_size_i     = size;
        mem_unsigned_i = uns;
        mem_addr_i     = addr;
        mem_wdata_i    = wdata;
    endtask

    task automatic run_op(input vec_t v);
        int cyc = 0;
        int rd_p = 0;
        int wr_p = 0;
        bit seen = 1'b0;
        bit gap = 1'b0;
        bit spur = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", {31'd0, lsu_done_o}, 32'd0);
        chk("idle_addr", cpu_addr_o, 32'd0);
        drive_op(v.we, v.size, v.uns, v.addr, v.wdata);
        cache_stall_i = 1'b0;
        cpu_rd_data_i = v.rd;
        #1;
        chk("accept_stall", {31'd0, lsu_stall_o}, 32'd1);
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            cache_stall_i = (cyc >= 2 && cyc <= v.stalls + 1);
            if (cpu_rd_req_o) rd_p++;
            if (cpu_wr_req_o) wr_p++;
            if (misalign_o || bus_err_o) spur = 1'b1;
            if (cyc == 1) begin
                chk("req_addr", cpu_addr_o, v.e_addr);
                chk("req_mask", {28'd0, cpu_wr_en_o}, {28'd0, v.e_mask});
                if (v.we) chk("req_wdata", cpu_wr_data_o, v.e_wdata);
            end
            if (lsu_done_o) seen = 1'b1;
            else if (!lsu_stall_o) gap = 1'b1;
        end
        chk("done_latency", cyc, 3 + v.stalls);
        chk("done_rdata", lsu_rdata_o, v.e_rdata);
        chk("done_stall_low", {31'd0, lsu_stall_o}, 32'd0);
        chk("done_addr_held", cpu_addr_o, v.e_addr);
        chk("done_mask_held", {28'd0, cpu_wr_en_o}, {28'd0, v.e_mask});
        chk("rd_req_pulses", rd_p, v.we ? 0 : 1);
        chk("wr_req_pulses", wr_p, v.we ? 1 : 0);
        chk("stall_gap", {31'd0, gap}, 32'd0);
        chk("spurious_err", {31'd0, spur}, 32'd0);
        mem_req_i     = 1'b0;
        cache_stall_i = 1'b0;
    endtask

    task automatic run_bad(input bad_t b);
        @(posedge clk); #1;
        drive_op(b.we, b.size, 1'b0, b.addr, 32'h1234_5678);
        #1;
        chk("bad_stall", {31'd0, lsu_stall_o}, 32'd0);
        @(posedge clk); #1;
        chk("bad_misalign", {31'd0, misalign_o}, 32'd1);
        chk("bad_no_req", {30'd0, cpu_rd_req_o, cpu_wr_req_o}, 32'd0);
        chk("bad_addr", cpu_addr_o, 32'd0);
        mem_req_i = 1'b0;
        @(posedge clk); #1;
        chk("bad_pulse_end", {31'd0, misalign_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int cyc;
        //          we    size   uns   addr          wdata         rd            st addr          mask     wdata         rdata
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 0, 32'h0000_1004, 4'b0000, 32'h0,        32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 32'h0000_1000, 4'b0000, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0,        32'h8001_1234, 0, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_8001};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 32'h0000_2002, 32'h1234_56A5, 32'hFFFF_FFFF, 0, 32'h0000_2000, 4'b0100, 32'hA5A5_A5A5, 32'h0};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hFFFF_1234, 32'hFFFF_FFFF, 0, 32'h0000_2000, 4'b1100, 32'h1234_1234, 32'h0};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_1008, 32'h0,        32'h0BAD_F00D, 7, 32'h0000_1008, 4'b0000, 32'h0,        32'h0BAD_F00D};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h0000_3000, 32'hCAFE_F00D, 32'h0,        2, 32'h0000_3000, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h0000_1000, 32'h0,        32'h1234_F00D, 0, 32'h0000_1000, 4'b0000, 32'h0,        32'h0000_F00D};
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h0000_1000, 32'h0,        32'h1234_F00D, 0, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_F00D};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0,        32'h0000_7F00, 1, 32'h0000_1000, 4'b0000, 32'h0,        32'h0000_007F};
        vecs[11] = '{1'b1, 2'b00, 1'b0, 32'h0000_2001, 32'h0000_005A, 32'h0,        0, 32'h0000_2000, 4'b0010, 32'h5A5A_5A5A, 32'h0};
        bads[0]  = '{1'b0, 2'b10, 32'h0000_1001};
        bads[1]  = '{1'b0, 2'b01, 32'h0000_1003};
        bads[2]  = '{1'b0, 2'b11, 32'h0000_1000};
        bads[3]  = '{1'b1, 2'b10, 32'h0000_2002};

        rst = 1'b1;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_unsigned_i = 1'b0;
        mem_addr_i = '0; mem_wdata_i = '0; cpu_rd_data_i = '0; cache_stall_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {26'd0, cpu_rd_req_o, cpu_wr_req_o, lsu_stall_o, lsu_done_o,
                            misalign_o, bus_err_o}, 32'd0);
        chk("rst_addr", cpu_addr_o, 32'd0);
        chk("rst_wdata", cpu_wr_data_o | {28'd0, cpu_wr_en_o}, 32'd0);
        chk("rst_rdata", lsu_rdata_o, 32'd0);
        rst = 1'b0;

        // Table vectors run back to back: each accept lands in the IDLE cycle after DONE.
        for (int i = 0; i < 12; i++) run_op(vecs[i]);
        for (int i = 0; i < 4; i++) run_bad(bads[i]);

        // Watchdog: cache never answers.
        @(posedge clk); #1;
        drive_op(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0);
        cache_stall_i = 1'b1;
        cyc = 0;
        while (!bus_err_o && !lsu_done_o && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("timeout_cycle", cyc, 18);
        chk("timeout_bus_err", {31'd0, bus_err_o}, 32'd1);
        chk("timeout_no_done", {31'd0, lsu_done_o}, 32'd0);
        chk("timeout_addr", cpu_addr_o, 32'd0);
        mem_req_i = 1'b0;
        cache_stall_i = 1'b0;
        #1;
        chk("timeout_stall", {31'd0, lsu_stall_o}, 32'd0);
        @(posedge clk); #1;
        chk("timeout_pulse_end", {31'd0, bus_err_o}, 32'd0);

        // Reset in the middle of a stalled store.
        @(posedge clk); #1;
        drive_op(1'b1, 2'b10, 1'b0, 32'h0000_3000, 32'hCAFE_F00D);
        cache_stall_i = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_addr", cpu_addr_o, 32'h0000_3000);
        #2;
        rst = 1'b1;
        mem_req_i = 1'b0;
        #1;
        chk("mid_rst_ctrl", {26'd0, cpu_rd_req_o, cpu_wr_req_o, lsu_stall_o, lsu_done_o,
                             misalign_o, bus_err_o}, 32'd0);
        chk("mid_rst_addr", cpu_addr_o, 32'd0);
        chk("mid_rst_wdata", cpu_wr_data_o, 32'd0);
        chk("mid_rst_mask", {28'd0, cpu_wr_en_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cache_stall_i = 1'b0;
        run_op(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store control stage in the MEM pipeline stage, directly upstream of the data-cache top. It accepts one load or store per transaction from the EX/MEM register, checks alignment, and builds the byte-lane write mask and replicated write data. It issues a single-cycle cache request, waits out the cache stall, then sign- or zero-extends load data for write-back. It stalls the pipeline for the whole transaction and runs a watchdog that aborts a transaction when the cache never answers.

Parameters:
ADDR_W, 32, address width (RV32).
DATA_W, 32, data width.
TIMEOUT_CYC, 1024, maximum number of WAIT cycles before abort; minimum 2.
CNT_W, 11, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
mem_req_i  in  1  EX/MEM holds a memory op; held stable while lsu_stall_o=1.
mem_we_i  in  1  1=store, 0=load.
mem_size_i  in  2  00=byte, 01=half, 10=word; 11 is illegal.
mem_unsigned_i  in  1  zero-extend load (LBU/LHU).
mem_addr_i  in  ADDR_W  byte address.
mem_wdata_i  in  DATA_W  store data, right-aligned.
cpu_rd_req_o  out  1  cache read request, one-cycle pulse.
cpu_wr_req_o  out  1  cache write request, one-cycle pulse.
cpu_addr_o  out  ADDR_W  word address, bits [1:0] forced to 0.
cpu_wr_data_o  out  DATA_W  lane-replicated store data.
cpu_wr_en_o  out  4  byte-lane write mask.
cpu_rd_data_i  in  DATA_W  cache read word.
cache_stall_i  in  1  cache busy (miss/refill/writeback).
lsu_stall_o  out  1  freeze IF/ID/EX.
lsu_done_o  out  1  one-cycle pulse: transaction retired.
lsu_rdata_o  out  DATA_W  extended load result; valid with lsu_done_o.
misalign_o  out  1  one-cycle pulse: misaligned or illegal-size op, no cache access.
bus_err_o  out  1  one-cycle pulse: watchdog abort.

Behaviour:
- Reset values: state IDLE; every output 0; watchdog counter 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE with mem_req_i=1 and a legal op:
  - latch address, size, signedness, mask and data;
  - go to REQ.
- IDLE with mem_req_i=1 and an illegal op:
  - illegal means size=11, half with addr[0]=1, or word with addr[1:0]!=0;
  - pulse misalign_o next cycle; stay in IDLE; no cache request.
- REQ: exactly one cycle. Assert cpu_rd_req_o or cpu_wr_req_o (registered); clear the counter; go to WAIT.
- WAIT:
  - cache_stall_i=1: increment the counter;
  - counter reaching TIMEOUT_CYC-1 while stalled: go to IDLE and pulse bus_err_o;
  - cache_stall_i=0: capture cpu_rd_data_i (loads only) and go to DONE.
- DONE: one cycle. lsu_done_o=1, lsu_rdata_o valid; go to IDLE.
- lsu_stall_o is combinational:
  - 1 when state is REQ or WAIT;
  - 1 in IDLE when mem_req_i is high and the op is legal;
  - 0 in DONE, so the pipeline advances on the done cycle.
- Hit latency: accept→DONE is 3 cycles (IDLE→REQ→WAIT→DONE); every stalled WAIT cycle adds 1.
- Write mask:
  - SB: 0001<<addr[1:0];
  - SH: 0011<<{addr[1],1'b0};
  - SW: 1111.
- Write data:
  - SB: {4{wdata[7:0]}};
  - SH: {2{wdata[15:0]}};
  - SW: wdata.
- Loads: cpu_wr_en_o=0000.
- Load extract: byte lane addr[1:0], or half lane addr[1]. Sign-extend from bit 7/15 unless mem_unsigned_i=1. Stores: lsu_rdata_o=0.
- cpu_addr_o, cpu_wr_data_o and cpu_wr_en_o hold their latched values from REQ through DONE; they are 0 in IDLE.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately after DONE. There is no accept in DONE itself.
- Abort and misalign pulses never coincide with lsu_done_o.
- Reset mid-transaction: return to IDLE immediately. A cache request already issued is dropped; the cache top shares the same reset.

Test Plan:
- Aligned LW at 0x0000_1004, cache_stall_i=0, rd_data=0xDEAD_BEEF → cpu_rd_req_o pulse with addr 0x1004; lsu_done_o 3 cycles after accept; lsu_rdata_o=0xDEAD_BEEF; lsu_stall_o high for 3 cycles.
- LB at 0x1003 with rd_data=0x80FF_0000 → lsu_rdata_o=0xFFFF_FF80. LBU at the same address → 0x0000_0080. LH at 0x1002 with rd_data=0x8001_1234 → 0xFFFF_8001.
- SB 0xA5 at 0x2002 → cpu_wr_en_o=0100, cpu_wr_data_o=0xA5A5_A5A5, cpu_addr_o=0x2000, cpu_wr_req_o single pulse. SH 0x1234 at 0x2002 → mask 1100, data 0x1234_1234.
- Miss: cache_stall_i high for 7 WAIT cycles → lsu_done_o 10 cycles after accept; lsu_stall_o high throughout the transaction and low in DONE.
- LW at 0x1001 and LH at 0x1003 → misalign_o pulse for each; no cpu_*_req_o; lsu_stall_o=0; FSM stays in IDLE.
- cache_stall_i stuck high with TIMEOUT_CYC=16 → bus_err_o pulse after 16 WAIT cycles, return to IDLE. Assert rst mid-WAIT on a separate run → all outputs 0 immediately.
